// File: rtl/matrix_mac_sequencer_pkg.sv
// Shared constants for the 2x2 matrix multiplier: widths, sequencer states,
// result slot layout and the entry-to-element mapping used by the selectors.
package matrix_mac_sequencer_pkg;

  localparam int unsigned ELEM_W  = 4;
  localparam int unsigned ACC_W   = 2 * ELEM_W + 1;
  localparam int unsigned N_ENTRY = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned N_SLOT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FINAL
  } state_t;

  // Element codes: 0=x00, 1=x01, 2=x10, 3=x11; entry 7 in the top bits.
  localparam logic [2*N_ENTRY-1:0] ENTRY_A_SEL = {2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
  localparam logic [2*N_ENTRY-1:0] ENTRY_B_SEL = {2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};

  function automatic int unsigned slot_lsb(input int unsigned k);
    return k * ACC_W;
  endfunction

endpackage

// File: rtl/matrix_mac_sequencer_mac.sv
// Multiply/pair-accumulate datapath: even entries load the product, odd
// entries close a dot product into the matching working slot.
module matrix_mac_unit
  import matrix_mac_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_capture,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [ELEM_W-1:0] i_a,
  input  logic [ELEM_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_slot0,
  output logic [ACC_W-1:0]  o_slot1,
  output logic [ACC_W-1:0]  o_slot2,
  output logic [ACC_W-1:0]  o_sum
);

  logic [2*ELEM_W-1:0] r_acc;
  logic [ACC_W-1:0]    r_slot0;
  logic [ACC_W-1:0]    r_slot1;
  logic [ACC_W-1:0]    r_slot2;
  logic [2*ELEM_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_sum;

  assign w_prod = i_a * i_b;
  assign w_sum  = ACC_W'(r_acc) + ACC_W'(w_prod);

  // Slot 3 is never stored here: the top consumes o_sum directly at its final capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else if (i_capture) begin
      if (!i_idx[0]) begin
        r_acc <= w_prod;
      end else begin
        case (i_idx[2:1])
          2'd0:    r_slot0 <= w_sum;
          2'd1:    r_slot1 <= w_sum;
          2'd2:    r_slot2 <= w_sum;
          default: ;
        endcase
      end
    end
  end

  assign o_slot0 = r_slot0;
  assign o_slot1 = r_slot1;
  assign o_slot2 = r_slot2;
  assign o_sum   = w_sum;

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Sequencer for the 2x2 multiplier: walks entry_out 0..7, captures the
// selector outputs one cycle later and publishes C = A*B with a done pulse.
module matrix_mac_sequencer
  import matrix_mac_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ELEM_W-1:0]     elementA,
  input  logic [ELEM_W-1:0]     elementB,
  output logic [IDX_W-1:0]      entry_out,
  output logic                  busy,
  output logic                  done,
  output logic [4*ACC_W-1:0]    result
);

  state_t               r_state;
  logic [IDX_W-1:0]     r_entry;
  logic                 r_busy;
  logic                 r_done;
  logic [4*ACC_W-1:0]   r_result;

  logic                 w_capture;
  logic [ACC_W-1:0]     w_slot0;
  logic [ACC_W-1:0]     w_slot1;
  logic [ACC_W-1:0]     w_slot2;
  logic [ACC_W-1:0]     w_sum;

  // Selector data lags the index by one edge, so the element on the bus at
  // each ISSUE/FINAL edge belongs to the index currently held in r_entry.
  assign w_capture = (r_state == ST_ISSUE) || (r_state == ST_FINAL);

  matrix_mac_unit u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_capture),
    .i_idx     (r_entry),
    .i_a       (elementA),
    .i_b       (elementB),
    .o_slot0   (w_slot0),
    .o_slot1   (w_slot1),
    .o_slot2   (w_slot2),
    .o_sum     (w_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_entry  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_entry <= '0;
          if (start) begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_entry <= r_entry + IDX_W'(1);
          if (r_entry == IDX_W'(N_ENTRY - 2)) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_result[slot_lsb(0) +: ACC_W] <= w_slot0;
          r_result[slot_lsb(1) +: ACC_W] <= w_slot1;
          r_result[slot_lsb(2) +: ACC_W] <= w_slot2;
          r_result[slot_lsb(3) +: ACC_W] <= w_sum;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_entry <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign entry_out = r_entry;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: behavioural negedge selectors feed the DUT,
// results are compared against a plain-arithmetic 2x2 product.
module tb_matrix_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  elementA;
  logic [3:0]  elementB;
  logic [2:0]  entry_out;
  logic        busy;
  logic        done;
  logic [35:0] result;

  logic [15:0] mA;
  logic [15:0] mB;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .elementA  (elementA),
    .elementB  (elementB),
    .entry_out (entry_out),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Selector models: register the addressed element on the falling edge.
  always @(negedge clk) begin
    case (entry_out)
      3'd0: begin elementA <= mA[3:0];   elementB <= mB[3:0];   end
      3'd1: begin elementA <= mA[7:4];   elementB <= mB[11:8];  end
      3'd2: begin elementA <= mA[3:0];   elementB <= mB[7:4];   end
      3'd3: begin elementA <= mA[7:4];   elementB <= mB[15:12]; end
      3'd4: begin elementA <= mA[11:8];  elementB <= mB[3:0];   end
      3'd5: begin elementA <= mA[15:12]; elementB <= mB[11:8];  end
      3'd6: begin elementA <= mA[11:8];  elementB <= mB[7:4];   end
      default: begin elementA <= mA[15:12]; elementB <= mB[15:12]; end
    endcase
  end

  function automatic int el(input logic [15:0] m, input int r, input int c);
    return int'(m[(r*2+c)*4 +: 4]);
  endfunction

  function automatic logic [35:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [35:0] res;
    res = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        res[(r*2+c)*9 +: 9] = 9'(el(a, r, 0) * el(b, 0, c) + el(a, r, 1) * el(b, 1, c));
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full multiply; optionally re-pulses start mid-run or leaves it held.
  task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit repulse, input bit hold);
    int cyc;
    bit seq_ok;
    mA = a;
    mB = b;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    check({tag, "_entry0"}, 64'(entry_out), 64'd0);
    cyc = 0;
    seq_ok = 1'b1;
    while (!done && cyc < 20) begin
      if (!hold) start = (repulse && (cyc == 2 || cyc == 4)) ? 1'b1 : 1'b0;
      step();
      cyc++;
      if (!done && cyc < 8 && entry_out != 3'(cyc)) seq_ok = 1'b0;
    end
    if (!hold) start = 1'b0;
    check({tag, "_entry_seq"}, 64'(seq_ok), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'd8);
    check({tag, "_result"}, 64'(result), 64'(model(a, b)));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_entry_done"}, 64'(entry_out), 64'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    logic [35:0] prev;
    reset = 1'b1;
    start = 1'b0;
    mA = '0;
    mB = '0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_entry", 64'(entry_out), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    step();

    run_mult("basic", {4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 1'b0, 1'b0);
    check("basic_c00", 64'(result[8:0]), 64'd19);
    check("basic_c11", 64'(result[35:27]), 64'd50);
    step();
    check("basic_done_pulse", 64'(done), 64'd0);

    run_mult("max", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check("max_slots", 64'(result), 64'({9'h1C2, 9'h1C2, 9'h1C2, 9'h1C2}));
    step();

    // Identity A, then hold start high across two back-to-back runs.
    run_mult("ident", {4'd1, 4'd0, 4'd0, 4'd1}, {4'd12, 4'd11, 4'd10, 4'd9}, 1'b0, 1'b1);
    check("ident_eq_b", 64'(result), 64'({9'd12, 9'd11, 9'd10, 9'd9}));
    prev = result;
    cyc = 0;
    step();
    cyc++;
    while (!done && cyc < 30) begin
      step();
      cyc++;
    end
    start = 1'b0;
    check("b2b_interval", 64'(cyc), 64'd9);
    check("b2b_result", 64'(result), 64'(prev));
    step();

    run_mult("repulse", {4'd3, 4'd9, 4'd14, 4'd2}, {4'd7, 4'd1, 4'd5, 4'd11}, 1'b1, 1'b0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) n_done++;
    end
    check("repulse_single_done", 64'(n_done), 64'd0);

    // Reset during the 5th cycle of a run.
    run_mult("pre_rst", {4'd5, 4'd6, 4'd7, 4'd8}, {4'd1, 4'd2, 4'd3, 4'd4}, 1'b0, 1'b0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_entry", 64'(entry_out), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n_done++;
      step();
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    run_mult("post_rst", {4'd2, 4'd13, 4'd6, 4'd10}, {4'd15, 4'd4, 4'd8, 4'd3}, 1'b0, 1'b0);
    step();

    for (int t = 0; t < 6; t++) begin
      run_mult($sformatf("rand%0d", t), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
